inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader_pkg.sv | 33 +++
 rtl/inst_loader_word_pack.sv | 55 +++++
 rtl/inst_loader.sv | 150 +++++++++++++++
 tb/tb_inst_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// ============================================================================
// Module : inst_loader_pkg
// Brief  : Shared states, byte/word geometry and state decode for inst_loader.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam int c_byte_w         = 8;
  localparam int c_hdr_len        = 2;
  localparam int c_bytes_per_word = 4;
  localparam int c_word_w         = c_byte_w * c_bytes_per_word;
  localparam int c_len_w          = c_byte_w * c_hdr_len;

  // States in which the byte stream is consumed and the load counts as busy.
  function automatic logic is_busy(input state_t s);
    return (s inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK});
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_loader_word_pack.sv
// ============================================================================
// Module : inst_loader_word_pack
// Brief  : Packs 4 bytes (first byte MSB) into a word, pulses word_vld_o once.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader_word_pack
  import inst_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                byte_vld_i,
  input  logic [c_byte_w-1:0] byte_i,
  output logic [1:0]          cnt_o,
  output logic                word_vld_o,
  output logic [c_word_w-1:0] word_o
);

  logic [c_word_w-c_byte_w-1:0] sr_q;
  logic [1:0]                   cnt_q;
  logic                         vld_q;
  logic [c_word_w-1:0]          word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      vld_q <= 1'b0;
      if (clr_i) begin
        cnt_q <= '0;
      end else if (byte_vld_i) begin
        if (cnt_q == 2'd3) begin
          word_q <= {sr_q, byte_i};
          vld_q  <= 1'b1;
          cnt_q  <= '0;
        end else begin
          sr_q  <= {sr_q[c_word_w-2*c_byte_w-1:0], byte_i};
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign word_vld_o = vld_q;
  assign word_o     = word_q;

endmodule

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module : inst_loader
// Brief  : Loads a length-prefixed byte stream into instruction memory.
//          Optional trailing checksum byte: define INST_LOADER_CHECKSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ABITS     = 32,
  parameter int DBITS     = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t c_end_st = S_CHK;
  logic [c_byte_w-1:0] sum_q, sum_d;
`else
  localparam state_t c_end_st = S_DONE;
`endif
  localparam logic [c_len_w:0] c_max_len = (c_len_w+1)'(MAX_WORDS);

  state_t             state_q, state_d;
  logic [c_len_w-1:0] len_q, len_d;
  logic [ABITS-1:0]   idx_q, idx_d, mem_addr_q;
  logic               busy_q, done_q, err_q, cpu_hold_q;

  logic               w_acc, w_data_acc, w_load, w_word_vld;
  logic [1:0]         w_cnt;
  logic [c_word_w-1:0] w_word;
  logic [c_len_w-1:0] w_len_full;
  logic [ABITS-1:0]   w_idx_inc;

  assign w_acc      = in_valid & busy_q;
  assign w_data_acc = w_acc && (state_q == S_DATA);
  assign w_load     = start && (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign w_len_full = {len_q[c_len_w-1:c_byte_w], in_data};
  assign w_idx_inc  = idx_q + ABITS'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (w_load) begin
      state_d = S_LEN_HI;
      len_d   = '0;
      idx_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      case (state_q)
        S_LEN_HI: if (w_acc) begin
          len_d[c_len_w-1:c_byte_w] = in_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: if (w_acc) begin
          len_d[c_byte_w-1:0] = in_data;
          if ({1'b0, w_len_full} > c_max_len) state_d = S_ERR;
          else if (w_len_full == '0)          state_d = c_end_st;
          else                                state_d = S_DATA;
        end
        S_DATA: if (w_acc) begin
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          // Leave DATA on the edge that launches the last word's write.
          if (w_cnt == 2'd3) begin
            idx_d = w_idx_inc;
            if (w_idx_inc == ABITS'(len_q)) state_d = c_end_st;
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHK: if (w_acc) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      cpu_hold_q <= is_busy(state_d) || (state_d == S_ERR);
      if (w_data_acc && (w_cnt == 2'd3)) mem_addr_q <= idx_q;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  inst_loader_word_pack u_word_pack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (w_load),
    .byte_vld_i (w_data_acc),
    .byte_i     (in_data),
    .cnt_o      (w_cnt),
    .word_vld_o (w_word_vld),
    .word_o     (w_word)
  );

  assign in_ready = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;
  assign mem_we   = w_word_vld;
  assign mem_addr = mem_addr_q;
  assign mem_din  = DBITS'(w_word);

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module : tb_inst_loader
// Brief  : Randomised scoreboard bench for inst_loader (honours
//          INST_LOADER_CHECKSUM_EN when defined for the build).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;

  localparam int ABITS     = 32;
  localparam int DBITS     = 32;
  localparam int MAX_WORDS = 1024;

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [7:0]       in_data;
  logic             in_ready, mem_we, busy, done, err, cpu_hold;
  logic [ABITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_din;

  always #5 clk = ~clk;

  inst_loader #(.ABITS(ABITS), .DBITS(DBITS), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] pay[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=none", mem_addr, mem_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(e.addr));
        chk("write_data", 64'(mem_din), 64'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    int n;
    int k;
    if (gaps) begin
      in_valid = 1'b0;
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic finish_load(input bit exp_err);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 20) begin @(negedge clk); k++; end
    chk("busy_cleared", 64'(busy), 64'(0));
    @(negedge clk);
    chk("done", 64'(done), 64'(!exp_err));
    chk("err", 64'(err), 64'(exp_err));
    chk("cpu_hold", 64'(cpu_hold), 64'(exp_err));
    chk("pending_writes", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Reference: N words taken from pay, checksum = byte sum mod 256.
  task automatic run_load(input logic [15:0] n, input bit gaps, input int start_at,
                          input bit ovr, input logic [7:0] ovr_val);
    bit         exp_err;
    logic [7:0] sum;
    logic [7:0] ck;
    sum = 8'h00;
    exp_err = (int'(n) > MAX_WORDS);
    if (!exp_err) begin
      for (int w = 0; w < int'(n); w++) begin
        wr_t e;
        e.addr = 32'(w);
        e.data = {pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]};
        exp_q.push_back(e);
        sum = sum + pay[4*w] + pay[4*w+1] + pay[4*w+2] + pay[4*w+3];
      end
    end
    ck = ovr ? ovr_val : sum;
`ifdef INST_LOADER_CHECKSUM_EN
    if (!exp_err && ck != sum) exp_err = 1'b1;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_clears", 64'({busy, done, err}), 64'(3'b100));
    @(posedge clk); #1;
    send_byte(n[15:8], gaps, 1'b0);
    send_byte(n[7:0], gaps, 1'b0);
    if (int'(n) <= MAX_WORDS) begin
      for (int i = 0; i < 4 * int'(n); i++) send_byte(pay[i], gaps, i == start_at);
`ifdef INST_LOADER_CHECKSUM_EN
      send_byte(ck, gaps, 1'b0);
`endif
    end
    finish_load(exp_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 64'({in_ready, mem_we, busy, done, err, cpu_hold}), 64'(0));
    chk("reset_addr", 64'(mem_addr), 64'(0));
    chk("reset_din", 64'(mem_din), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word reference load.
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    run_load(16'h0002, 1'b0, -1, 1'b0, 8'h00);

    // Empty program.
    pay = '{};
    run_load(16'h0000, 1'b0, -1, 1'b0, 8'h00);

    // Length one past the limit.
    run_load(16'h0401, 1'b0, -1, 1'b0, 8'h00);

`ifdef INST_LOADER_CHECKSUM_EN
    // One word with a wrong checksum: write still happens, then error.
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16'h0001, 1'b0, -1, 1'b1, 8'h00);
`endif

    // Reset in the middle of a load, coinciding with a presented byte.
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(pay[0], 1'b0, 1'b0);
    send_byte(pay[1], 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = pay[2];
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_abort_flags", 64'({in_ready, mem_we, busy, done, err, cpu_hold}), 64'(0));
    chk("rst_abort_addr_din", 64'({mem_addr, mem_din}), 64'(0));
    repeat (6) @(negedge clk);
    chk("rst_abort_no_writes", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;

    // Randomised loads, with gaps and stray start pulses while busy.
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 6);
      pay = '{};
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
      run_load(16'(n), bit'(t % 2), int'($urandom_range(0, 4 * n - 1)), 1'b0, 8'h00);
      run_load(16'(n), bit'((t + 1) % 2), -1, 1'b0, 8'h00);
    end

    // Largest accepted program.
    pay = '{};
    for (int i = 0; i < 4 * MAX_WORDS; i++) pay.push_back(8'($urandom));
    run_load(16'(MAX_WORDS), 1'b0, -1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
